// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end for the shared 16-bit ALU.
// Runs one operation at a time: single-cycle ALU ops pass straight through,
// while mul (op 101) is a 16-step shift-and-add that reuses the ALU adder.
// Each result is held for the requester that issued it until that requester takes it.
module alu_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [15:0] resp0_result,
  output logic        resp0_zero,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [15:0] resp1_result,
  output logic        resp1_zero,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_control,
  input  logic [15:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b101;

  state_t      state_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [2:0]  op_q;
  logic        owner_q;
  logic        last_grant_q;
  logic [15:0] acc_q;
  logic [3:0]  count_q;
  logic [15:0] res0_q;
  logic [15:0] res1_q;
  logic        zero0_q;
  logic        zero1_q;
  logic        rv0_q;
  logic        rv1_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [2:0]  alu_ctl_q;

  logic        grant0_s;
  logic        grant1_s;
  logic        accept_s;
  logic        sel_s;
  logic [15:0] sel_a_s;
  logic [15:0] sel_b_s;
  logic [2:0]  sel_op_s;
  logic [3:0]  count_nx_s;
  logic        owner_ready_s;

  // Shifted partial product for one multiplier bit; zero when that bit is clear.
  function automatic logic [15:0] partial_product(input logic [15:0] a,
                                                  input logic [15:0] b,
                                                  input logic [3:0]  idx);
    logic [15:0] pp;
    if (b[idx]) begin
      pp = a << idx;
    end else begin
      pp = 16'd0;
    end
    return pp;
  endfunction

  // Round-robin grant: only offered in IDLE and never while reset is high.
  // last_grant_q = 1 means req1 went last, so req0 wins a tie.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == IDLE) && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0_s = last_grant_q;
        grant1_s = ~last_grant_q;
      end else begin
        grant0_s = req0_valid;
        grant1_s = req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Operand mux for the granted requester, the next step index, and the owner's resp_ready.
  always_comb begin
    sel_s    = grant1_s;
    accept_s = grant0_s | grant1_s;
    if (grant1_s) begin
      sel_a_s  = req1_a;
      sel_b_s  = req1_b;
      sel_op_s = req1_op;
    end else begin
      sel_a_s  = req0_a;
      sel_b_s  = req0_b;
      sel_op_s = req0_op;
    end
    count_nx_s = count_q + 4'd1;
    if (owner_q) begin
      owner_ready_s = resp1_ready;
    end else begin
      owner_ready_s = resp0_ready;
    end
  end

  // Sequencer FSM: accept, single-cycle execute or multiply stepping, then hold the response.
  // ALU inputs are registered and always set up one cycle ahead of the state that uses them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      a_q          <= 16'd0;
      b_q          <= 16'd0;
      op_q         <= 3'b000;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      acc_q        <= 16'd0;
      count_q      <= 4'd0;
      res0_q       <= 16'd0;
      res1_q       <= 16'd0;
      zero0_q      <= 1'b0;
      zero1_q      <= 1'b0;
      rv0_q        <= 1'b0;
      rv1_q        <= 1'b0;
      alu_a_q      <= 16'd0;
      alu_b_q      <= 16'd0;
      alu_ctl_q    <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            a_q          <= sel_a_s;
            b_q          <= sel_b_s;
            op_q         <= sel_op_s;
            owner_q      <= sel_s;
            last_grant_q <= sel_s;
            if (sel_op_s == OP_MUL) begin
              state_q   <= MUL;
              acc_q     <= 16'd0;
              count_q   <= 4'd0;
              alu_a_q   <= 16'd0;
              alu_b_q   <= partial_product(sel_a_s, sel_b_s, 4'd0);
              alu_ctl_q <= OP_ADD;
            end else begin
              state_q   <= EXEC;
              alu_a_q   <= sel_a_s;
              alu_b_q   <= sel_b_s;
              alu_ctl_q <= sel_op_s;
            end
          end
        end
        EXEC: begin
          if (owner_q) begin
            res1_q  <= alu_result;
            zero1_q <= alu_zero;
            rv1_q   <= 1'b1;
          end else begin
            res0_q  <= alu_result;
            zero0_q <= alu_zero;
            rv0_q   <= 1'b1;
          end
          state_q   <= RESP;
          alu_a_q   <= 16'd0;
          alu_b_q   <= 16'd0;
          alu_ctl_q <= OP_ADD;
        end
        MUL: begin
          acc_q <= alu_result;
          if (count_q == 4'd15) begin
            if (owner_q) begin
              res1_q  <= alu_result;
              zero1_q <= alu_zero;
              rv1_q   <= 1'b1;
            end else begin
              res0_q  <= alu_result;
              zero0_q <= alu_zero;
              rv0_q   <= 1'b1;
            end
            state_q   <= RESP;
            count_q   <= 4'd0;
            alu_a_q   <= 16'd0;
            alu_b_q   <= 16'd0;
            alu_ctl_q <= OP_ADD;
          end else begin
            count_q   <= count_nx_s;
            alu_a_q   <= alu_result;
            alu_b_q   <= partial_product(a_q, b_q, count_nx_s);
            alu_ctl_q <= OP_ADD;
          end
        end
        RESP: begin
          if (owner_ready_s) begin
            if (owner_q) begin
              rv1_q <= 1'b0;
            end else begin
              rv0_q <= 1'b0;
            end
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req0_ready   = grant0_s;
  assign req1_ready   = grant1_s;
  assign resp0_valid  = rv0_q;
  assign resp1_valid  = rv1_q;
  assign resp0_result = res0_q;
  assign resp1_result = res1_q;
  assign resp0_zero   = zero0_q;
  assign resp1_zero   = zero1_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_control  = alu_ctl_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed tests for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [15:0] resp0_result, resp1_result;
  logic        resp0_zero, resp1_zero;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;
  logic        alu_zero;
  logic        busy;

  int pass_cnt;
  int total_cnt;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result), .resp1_zero(resp1_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU seen by the arbiter
  always_comb begin
    alu_result = 16'd0;
    case (alu_control)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 16'd1 : 16'd0;
      default: alu_result = alu_a + alu_b;
    endcase
    alu_zero = (alu_result == 16'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 1'b0, OP_ADD, 16'd0, 16'd0);
    set_req(1, 1'b0, OP_ADD, 16'd0, 16'd0);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Issue one request, wait (bounded) for grant and response, then take the response.
  task automatic run_op(input int port, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, output logic [15:0] res, output logic z,
                        output int lat, output logic ok);
    logic rdy;
    logic rv;
    int   w;
    ok = 1'b1; lat = 0; res = 16'd0; z = 1'b0; w = 0;
    set_req(port, 1'b1, op, a, b);
    #1;
    rdy = (port == 0) ? req0_ready : req1_ready;
    while (!rdy && w < 40) begin
      tick(); w++;
      rdy = (port == 0) ? req0_ready : req1_ready;
    end
    if (!rdy) begin
      ok = 1'b0;
      set_req(port, 1'b0, op, a, b);
    end else begin
      tick();
      set_req(port, 1'b0, op, a, b);
      rv = (port == 0) ? resp0_valid : resp1_valid;
      while (!rv && lat < 40) begin
        tick(); lat++;
        rv = (port == 0) ? resp0_valid : resp1_valid;
      end
      if (!rv) begin
        ok = 1'b0;
      end else begin
        res = (port == 0) ? resp0_result : resp1_result;
        z   = (port == 0) ? resp0_zero : resp1_zero;
        if (port == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
        tick();
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_req(0, 1'b1, OP_ADD, 16'h0001, 16'h0001);
    set_req(1, 1'b1, OP_ADD, 16'h0001, 16'h0001);
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    tick();
    total_cnt++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    else pass_cnt++;
    total_cnt++;
    if (busy !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0 ||
        resp0_result !== 16'd0 || resp1_result !== 16'd0 || resp0_zero !== 1'b0 || resp1_zero !== 1'b0)
      $display("FAIL reset_outputs: got busy=%b rv=%b%b r0=%h r1=%h z=%b%b expected all zero",
               busy, resp0_valid, resp1_valid, resp0_result, resp1_result, resp0_zero, resp1_zero);
    else pass_cnt++;
    total_cnt++;
    if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_control !== 3'b000)
      $display("FAIL reset_alu: got a=%h b=%h c=%b expected 0000 0000 000", alu_a, alu_b, alu_control);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_add();
    set_req(0, 1'b1, OP_ADD, 16'h0005, 16'h0007);
    #1;
    total_cnt++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL add_ready: got %b%b expected 10", req0_ready, req1_ready);
    else pass_cnt++;
    tick();
    set_req(0, 1'b0, OP_ADD, 16'h0005, 16'h0007);
    total_cnt++;
    if (busy !== 1'b1 || alu_a !== 16'h0005 || alu_b !== 16'h0007 || alu_control !== 3'b000 || resp0_valid !== 1'b0)
      $display("FAIL add_exec: got busy=%b a=%h b=%h c=%b rv=%b expected 1 0005 0007 000 0",
               busy, alu_a, alu_b, alu_control, resp0_valid);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (resp0_valid !== 1'b1 || resp0_result !== 16'h000C || resp0_zero !== 1'b0 || resp1_valid !== 1'b0)
      $display("FAIL add_resp: got rv0=%b r=%h z=%b rv1=%b expected 1 000c 0 0",
               resp0_valid, resp0_result, resp0_zero, resp1_valid);
    else pass_cnt++;
    total_cnt++;
    if (alu_a !== 16'd0 || alu_b !== 16'd0 || alu_control !== 3'b000)
      $display("FAIL add_resp_alu: got a=%h b=%h c=%b expected 0000 0000 000", alu_a, alu_b, alu_control);
    else pass_cnt++;
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    total_cnt++;
    if (resp0_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL add_done: got rv0=%b busy=%b expected 0 0", resp0_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_sub_slt();
    logic [15:0] r; logic z; int lat; logic ok;
    run_op(0, OP_SUB, 16'h0003, 16'h0003, r, z, lat, ok);
    total_cnt++;
    if (!ok || r !== 16'h0000 || z !== 1'b1 || lat != 1)
      $display("FAIL sub_zero: got ok=%b r=%h z=%b lat=%0d expected 1 0000 1 1", ok, r, z, lat);
    else pass_cnt++;
    run_op(1, OP_SLT, 16'h0002, 16'h0009, r, z, lat, ok);
    total_cnt++;
    if (!ok || r !== 16'h0001 || z !== 1'b0 || lat != 1)
      $display("FAIL slt: got ok=%b r=%h z=%b lat=%0d expected 1 0001 0 1", ok, r, z, lat);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int n0, n1, got, w, lat;
    logic [15:0] exp_res, got_res;
    logic rv, other_rv;
    do_reset();
    n0 = 0; n1 = 0;
    set_req(0, 1'b1, OP_ADD, 16'h0010, 16'h0001);
    set_req(1, 1'b1, OP_OR, 16'h0F00, 16'h0000);
    #1;
    for (int i = 0; i < 8; i++) begin
      w = 0;
      while (!(req0_ready || req1_ready) && w < 40) begin tick(); w++; end
      got = req1_ready ? 1 : 0;
      total_cnt++;
      if (!(req0_ready ^ req1_ready) || got != (i % 2)) begin
        $display("FAIL rr_grant%0d: got ready=%b%b expected port %0d", i, req0_ready, req1_ready, i % 2);
        break;
      end else pass_cnt++;
      tick();
      if (got == 0) begin
        exp_res = 16'h0011 + 16'(n0);
        n0++;
        set_req(0, (n0 < 4), OP_ADD, 16'h0010 + 16'(n0), 16'h0001);
      end else begin
        exp_res = 16'h0F00 | 16'(n1);
        n1++;
        set_req(1, (n1 < 4), OP_OR, 16'h0F00, 16'(n1));
      end
      lat = 0;
      rv = (got == 0) ? resp0_valid : resp1_valid;
      while (!rv && lat < 40) begin
        tick(); lat++;
        rv = (got == 0) ? resp0_valid : resp1_valid;
      end
      got_res  = (got == 0) ? resp0_result : resp1_result;
      other_rv = (got == 0) ? resp1_valid : resp0_valid;
      total_cnt++;
      if (!rv || other_rv || got_res !== exp_res)
        $display("FAIL rr_resp%0d: got rv=%b other=%b r=%h expected 1 0 %h", i, rv, other_rv, got_res, exp_res);
      else pass_cnt++;
      if (got == 0) resp0_ready = 1'b1; else resp1_ready = 1'b1;
      tick();
      resp0_ready = 1'b0;
      resp1_ready = 1'b0;
    end
    set_req(0, 1'b0, OP_ADD, 16'd0, 16'd0);
    set_req(1, 1'b0, OP_ADD, 16'd0, 16'd0);
  endtask

  task automatic test_mul();
    logic [15:0] r; logic z; int lat; logic ok;
    run_op(1, OP_MUL, 16'h012C, 16'h0005, r, z, lat, ok);
    total_cnt++;
    if (!ok || r !== 16'h05DC || z !== 1'b0 || lat != 16)
      $display("FAIL mul_basic: got ok=%b r=%h z=%b lat=%0d expected 1 05dc 0 16", ok, r, z, lat);
    else pass_cnt++;
    run_op(1, OP_MUL, 16'h0100, 16'h0100, r, z, lat, ok);
    total_cnt++;
    if (!ok || r !== 16'h0000 || z !== 1'b1)
      $display("FAIL mul_zero: got ok=%b r=%h z=%b expected 1 0000 1", ok, r, z);
    else pass_cnt++;
    run_op(0, OP_MUL, 16'hFFFF, 16'hFFFF, r, z, lat, ok);
    total_cnt++;
    if (!ok || r !== 16'h0001 || z !== 1'b0 || lat != 16)
      $display("FAIL mul_ffff: got ok=%b r=%h z=%b lat=%0d expected 1 0001 0 16", ok, r, z, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    set_req(0, 1'b1, OP_ADD, 16'h1234, 16'h0001);
    #1;
    tick();
    set_req(0, 1'b0, OP_ADD, 16'h1234, 16'h0001);
    set_req(1, 1'b1, OP_SUB, 16'h0010, 16'h0001);
    tick();
    total_cnt++;
    if (resp0_valid !== 1'b1)
      $display("FAIL bp_resp_valid: got %b expected 1", resp0_valid);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (resp0_result !== 16'h1235 || resp0_zero !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL bp_hold%0d: got r=%h z=%b rdy1=%b busy=%b expected 1235 0 0 1",
                 i, resp0_result, resp0_zero, req1_ready, busy);
      else pass_cnt++;
      tick();
    end
    resp0_ready = 1'b1;
    tick();
    resp0_ready = 1'b0;
    total_cnt++;
    if (req1_ready !== 1'b1 || busy !== 1'b0 || resp0_valid !== 1'b0)
      $display("FAIL bp_idle_grant: got rdy1=%b busy=%b rv0=%b expected 1 0 0", req1_ready, busy, resp0_valid);
    else pass_cnt++;
    tick();
    set_req(1, 1'b0, OP_SUB, 16'h0010, 16'h0001);
    lat = 0;
    while (!resp1_valid && lat < 40) begin tick(); lat++; end
    total_cnt++;
    if (resp1_valid !== 1'b1 || resp1_result !== 16'h000F || lat != 1)
      $display("FAIL bp_req1: got rv1=%b r=%h lat=%0d expected 1 000f 1", resp1_valid, resp1_result, lat);
    else pass_cnt++;
    resp1_ready = 1'b1;
    tick();
    resp1_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    logic [15:0] r; logic z; int lat; logic ok; logic seen;
    set_req(0, 1'b1, OP_MUL, 16'h0003, 16'hFFFF);
    #1;
    tick();
    set_req(0, 1'b0, OP_MUL, 16'h0003, 16'hFFFF);
    repeat (8) tick();
    total_cnt++;
    if (busy !== 1'b1 || alu_a !== 16'h02FD || alu_b !== 16'h0300 || alu_control !== 3'b000)
      $display("FAIL mul_count8: got busy=%b a=%h b=%h c=%b expected 1 02fd 0300 000",
               busy, alu_a, alu_b, alu_control);
    else pass_cnt++;
    set_req(0, 1'b1, OP_ADD, 16'h0001, 16'h0001);
    reset = 1'b1;
    #1;
    total_cnt++;
    if (busy !== 1'b0 || alu_a !== 16'd0 || alu_b !== 16'd0 || alu_control !== 3'b000 ||
        resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || req0_ready !== 1'b0 ||
        resp0_result !== 16'd0 || resp1_result !== 16'd0 || resp0_zero !== 1'b0 || resp1_zero !== 1'b0)
      $display("FAIL midmul_reset: got busy=%b a=%h b=%h c=%b rv=%b%b rdy0=%b r0=%h r1=%h z=%b%b expected all zero",
               busy, alu_a, alu_b, alu_control, resp0_valid, resp1_valid, req0_ready,
               resp0_result, resp1_result, resp0_zero, resp1_zero);
    else pass_cnt++;
    tick();
    reset = 1'b0;
    set_req(0, 1'b0, OP_ADD, 16'h0001, 16'h0001);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp0_valid || resp1_valid || busy) seen = 1'b1;
      tick();
    end
    total_cnt++;
    if (seen !== 1'b0)
      $display("FAIL midmul_no_resp: got activity=%b expected 0", seen);
    else pass_cnt++;
    run_op(0, OP_ADD, 16'h0001, 16'h0001, r, z, lat, ok);
    total_cnt++;
    if (!ok || r !== 16'h0002 || z !== 1'b0 || lat != 1)
      $display("FAIL midmul_after: got ok=%b r=%h z=%b lat=%0d expected 1 0002 0 1", ok, r, z, lat);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_add();
    test_sub_slt();
    test_round_robin();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
